// File: rtl/hp48_sysram_responder_pkg.sv
// Shared definitions for the HP48 system RAM responder: bus command codes,
// configuration state encodings and the default RAM depth.
package hp48_sysram_responder_pkg;

    // Bus command codes carried on the nibble-serial HP48 bus.
    localparam logic [3:0] BUSCMD_NOP         = 4'h0;
    localparam logic [3:0] BUSCMD_PC_READ     = 4'h1;
    localparam logic [3:0] BUSCMD_DP_READ     = 4'h2;
    localparam logic [3:0] BUSCMD_PC_WRITE    = 4'h3;
    localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h4;
    localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h5;
    localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h6;
    localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h7;
    localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h8;
    localparam logic [3:0] BUSCMD_POLL        = 4'h9;
    localparam logic [3:0] BUSCMD_SHUTDOWN    = 4'hC;
    localparam logic [3:0] BUSCMD_RESET       = 4'hF;

    // Default RAM depth: 2^12 = 4096 nibbles.
    localparam int SYSRAM_DEPTH_LOG2_DEFAULT = 12;

    // Configuration handshake states.
    typedef enum logic [1:0] {
        SYSRAM_UNCONF = 2'd0,
        SYSRAM_SIZED  = 2'd1,
        SYSRAM_CONF   = 2'd2
    } sysram_state_e;

    // True for the commands that access the RAM window through a pointer.
    function automatic logic is_data_cmd(input logic [3:0] cmd);
        return (cmd == BUSCMD_PC_READ) || (cmd == BUSCMD_DP_READ) ||
               (cmd == BUSCMD_DP_WRITE);
    endfunction

endpackage

// File: rtl/hp48_sysram_responder_mem.sv
// Single-port synchronous nibble RAM, write-first: a write cycle also
// presents the written nibble on the registered read port.
module sysram_nibble_mem #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [3:0]            i_wdata,
    output logic [3:0]            o_rdata
);

    logic [3:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [3:0] r_rdata;

    // Array write and registered read; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
                r_rdata       <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/hp48_sysram_responder.sv
// HP48 system RAM responder: decodes strobed bus commands, keeps PC/DP
// nibble pointers, runs the two-step size/base configuration handshake on
// the daisy chain and serves a masked nibble RAM window.
// Optional feature macro: SYSRAM_UNMAPPED_ERR_EN (sticky bus_error on
// unmapped data accesses); without it bus_error is tied low.
// Handshake: command/address/nibble_in are qualified by a one-cycle strobe;
// there is no back-pressure, every strobed command is consumed in its cycle,
// and data-command results appear registered one cycle later.
module hp48_sysram_responder
    import hp48_sysram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = SYSRAM_DEPTH_LOG2_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe,
    input  logic [3:0]  command,
    input  logic [19:0] address,
    input  logic [3:0]  nibble_in,
    input  logic        daisy_in,
    output logic        daisy_out,
    output logic [3:0]  nibble_out,
    output logic        hit,
    output logic        bus_error,
    output logic [1:0]  o_dbg_state,
    output logic [19:0] o_dbg_pc_ptr,
    output logic [19:0] o_dbg_dp_ptr,
    output logic [19:0] o_dbg_mask,
    output logic [19:0] o_dbg_base
);

    sysram_state_e r_state;
    sysram_state_e w_state_next;
    logic [19:0]   r_pc_ptr;
    logic [19:0]   r_dp_ptr;
    logic [19:0]   r_mask;
    logic [19:0]   r_base;
    logic          r_hit;
    logic          w_load_mask;
    logic          w_load_base;
    logic          w_strobe_data;
    logic          w_cmd_reset;
    logic [19:0]   w_acc_addr;
    logic          w_hit;
    logic          w_ram_en;
    logic          w_ram_we;
    logic [3:0]    w_ram_rdata;

    assign w_strobe_data = strobe && is_data_cmd(command);
    assign w_cmd_reset   = strobe && (command == BUSCMD_RESET);
    assign w_acc_addr    = (command == BUSCMD_PC_READ) ? r_pc_ptr : r_dp_ptr;
    assign w_hit         = (r_state == SYSRAM_CONF) &&
                           ((w_acc_addr & r_mask) == r_base);

    // Only hitting accesses touch the RAM; a coincident reset blocks writes.
    assign w_ram_en = w_strobe_data && w_hit && !reset;
    assign w_ram_we = (command == BUSCMD_DP_WRITE);

    // Configuration next-state: CONFIGURE is taken only while this chip owns
    // the daisy chain and is not yet fully configured.
    always_comb begin
        w_state_next = r_state;
        w_load_mask  = 1'b0;
        w_load_base  = 1'b0;
        if (strobe) begin
            if (command == BUSCMD_RESET) begin
                w_state_next = SYSRAM_UNCONF;
            end else if (command == BUSCMD_CONFIGURE && daisy_in) begin
                if (r_state == SYSRAM_UNCONF) begin
                    w_state_next = SYSRAM_SIZED;
                    w_load_mask  = 1'b1;
                end else if (r_state == SYSRAM_SIZED) begin
                    w_state_next = SYSRAM_CONF;
                    w_load_base  = 1'b1;
                end
            end
        end
    end

    // State register plus size/base configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SYSRAM_UNCONF;
            r_mask  <= 20'h0;
            r_base  <= 20'h0;
        end else begin
            r_state <= w_state_next;
            if (w_cmd_reset) begin
                r_mask <= 20'h0;
                r_base <= 20'h0;
            end else begin
                if (w_load_mask) r_mask <= address;
                if (w_load_base) r_base <= address & r_mask;
            end
        end
    end

    // PC/DP pointers: load on LOAD_*, post-increment on every data access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_ptr <= 20'h0;
            r_dp_ptr <= 20'h0;
        end else if (strobe) begin
            case (command)
                BUSCMD_LOAD_PC:  r_pc_ptr <= address;
                BUSCMD_LOAD_DP:  r_dp_ptr <= address;
                BUSCMD_PC_READ:  r_pc_ptr <= r_pc_ptr + 20'h1;
                BUSCMD_DP_READ,
                BUSCMD_DP_WRITE: r_dp_ptr <= r_dp_ptr + 20'h1;
                default: ;
            endcase
        end
    end

    // Hit flag of the latest data access; it also gates the read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit <= 1'b0;
        end else if (w_strobe_data) begin
            r_hit <= w_hit;
        end
    end

`ifdef SYSRAM_UNMAPPED_ERR_EN
    logic r_bus_error;

    // Sticky error on an unmapped access, cleared by either kind of reset.
    always_ff @(posedge clk) begin
        if (reset || w_cmd_reset) begin
            r_bus_error <= 1'b0;
        end else if (w_strobe_data &&
                     (r_state == SYSRAM_UNCONF ||
                      (r_state == SYSRAM_CONF && !w_hit))) begin
            r_bus_error <= 1'b1;
        end
    end

    assign bus_error = r_bus_error;
`else
    assign bus_error = 1'b0;
`endif

    sysram_nibble_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .i_clk   (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_acc_addr[DEPTH_LOG2-1:0]),
        .i_wdata (nibble_in),
        .o_rdata (w_ram_rdata)
    );

    // A miss leaves the RAM output untouched, so the hit flag zeroes it.
    assign nibble_out   = r_hit ? w_ram_rdata : 4'h0;
    assign hit          = r_hit;
    assign daisy_out    = (r_state == SYSRAM_CONF);
    assign o_dbg_state  = r_state;
    assign o_dbg_pc_ptr = r_pc_ptr;
    assign o_dbg_dp_ptr = r_dp_ptr;
    assign o_dbg_mask   = r_mask;
    assign o_dbg_base   = r_base;

endmodule

// File: tb/tb_hp48_sysram_responder.sv
// Testbench for hp48_sysram_responder: directed scenarios plus random
// traffic against a behavioural model, with a queue-based response checker.
module tb_hp48_sysram_responder;
    import hp48_sysram_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe;
    logic [3:0]  command;
    logic [19:0] address;
    logic [3:0]  nibble_in;
    logic        daisy_in;
    logic        daisy_out;
    logic [3:0]  nibble_out;
    logic        hit;
    logic        bus_error;
    logic [1:0]  dbg_state;
    logic [19:0] dbg_pc, dbg_dp, dbg_mask, dbg_base;

    int tests = 0;
    int fails = 0;

    // Expected response: {check_data, bus_error, hit, nibble}
    logic [6:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    hp48_sysram_responder dut (
        .clk          (clk),
        .reset        (reset),
        .strobe       (strobe),
        .command      (command),
        .address      (address),
        .nibble_in    (nibble_in),
        .daisy_in     (daisy_in),
        .daisy_out    (daisy_out),
        .nibble_out   (nibble_out),
        .hit          (hit),
        .bus_error    (bus_error),
        .o_dbg_state  (dbg_state),
        .o_dbg_pc_ptr (dbg_pc),
        .o_dbg_dp_ptr (dbg_dp),
        .o_dbg_mask   (dbg_mask),
        .o_dbg_base   (dbg_base)
    );

    // ---------------- reference model ----------------
    // m_st: 0 = unconfigured, 1 = size received, 2 = fully configured
    int          m_st;
    logic [19:0] m_mask, m_base, m_pc, m_dp;
    logic        m_err;
    logic [3:0]  m_mem [4096];
    bit          m_wr  [4096];

    function automatic logic [1:0] m_state_code();
        if (m_st == 2) return SYSRAM_CONF;
        if (m_st == 1) return SYSRAM_SIZED;
        return SYSRAM_UNCONF;
    endfunction

    task automatic model_reset();
        m_st = 0; m_mask = 0; m_base = 0; m_pc = 0; m_dp = 0; m_err = 0;
    endtask

    task automatic model_cmd(input logic [3:0] cmd, input logic [19:0] a,
                             input logic [3:0] nib, input logic dai);
        logic [19:0] acc;
        logic        h, chk;
        logic [3:0]  d;
        int          idx;
        if (cmd == BUSCMD_PC_READ || cmd == BUSCMD_DP_READ || cmd == BUSCMD_DP_WRITE) begin
            acc = (cmd == BUSCMD_PC_READ) ? m_pc : m_dp;
            h   = (m_st == 2) && ((acc & m_mask) == m_base);
            idx = int'(acc % 20'd4096);
            if (cmd == BUSCMD_DP_WRITE && h) begin
                m_mem[idx] = nib;
                m_wr[idx]  = 1'b1;
            end
            d   = (h && cmd != BUSCMD_DP_WRITE) ? m_mem[idx] : 4'h0;
            chk = (cmd != BUSCMD_DP_WRITE) && (!h || m_wr[idx]);
`ifdef SYSRAM_UNMAPPED_ERR_EN
            if (m_st == 0 || (m_st == 2 && !h)) m_err = 1'b1;
`endif
            exp_q.push_back({chk, m_err, h, d});
            if (cmd == BUSCMD_PC_READ) m_pc = m_pc + 1;
            else                       m_dp = m_dp + 1;
        end else if (cmd == BUSCMD_LOAD_PC) begin
            m_pc = a;
        end else if (cmd == BUSCMD_LOAD_DP) begin
            m_dp = a;
        end else if (cmd == BUSCMD_CONFIGURE && dai) begin
            if (m_st == 0) begin
                m_mask = a; m_st = 1;
            end else if (m_st == 1) begin
                m_base = a & m_mask; m_st = 2;
            end
        end else if (cmd == BUSCMD_RESET) begin
            m_st = 0; m_mask = 0; m_base = 0; m_err = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [3:0] cmd, input logic [19:0] a,
                          input logic [3:0] nib = 4'h0, input logic dai = 1'b1);
        @(negedge clk);
        strobe = 1'b1; command = cmd; address = a; nibble_in = nib; daisy_in = dai;
        model_cmd(cmd, a, nib, dai);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            strobe = 1'b0; command = $urandom_range(15, 0); address = $urandom;
        end
    endtask

    task automatic apply_reset(input logic with_strobe, input logic [3:0] cmd, input logic [19:0] a);
        @(negedge clk);
        reset = 1'b1; strobe = with_strobe; command = cmd; address = a; daisy_in = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0; strobe = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 20'(dbg_state), 20'(SYSRAM_UNCONF));
        check({tag, "_daisy_out"}, 20'(daisy_out), 20'h0);
        check({tag, "_nibble_out"}, 20'(nibble_out), 20'h0);
        check({tag, "_hit"}, 20'(hit), 20'h0);
        check({tag, "_bus_error"}, 20'(bus_error), 20'h0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic       due;
        logic [6:0] e;
        forever begin
            @(posedge clk);
            due = strobe && !reset && is_data_cmd(command);
            @(negedge clk);
            if (due) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: response with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (hit !== e[4] || bus_error !== e[5] || (e[6] && nibble_out !== e[3:0])) begin
                        fails++;
                        $display("FAIL rsp: got nib=%h hit=%b err=%b expected nib=%h hit=%b err=%b (data checked=%b)",
                                 nibble_out, hit, bus_error, e[3:0], e[4], e[5], e[6]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  cmd;
        logic [19:0] a;
        logic        exp_err;
        reset = 1'b1; strobe = 1'b0; command = 0; address = 0; nibble_in = 0; daisy_in = 1'b1;
        for (int i = 0; i < 4096; i++) m_wr[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_pc", dbg_pc, 20'h0);
        check("reset_dp", dbg_dp, 20'h0);

        // Daisy chain gating: CONFIGURE without daisy_in is ignored.
        do_cmd(BUSCMD_CONFIGURE, 20'hFF000, 4'h0, 1'b0);
        idle(1);
        check("gated_state", 20'(dbg_state), 20'(SYSRAM_UNCONF));
        do_cmd(BUSCMD_LOAD_DP, 20'h70000);
        do_cmd(BUSCMD_DP_READ, 20'h0);
        idle(1);
`ifdef SYSRAM_UNMAPPED_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("gated_err", 20'(bus_error), 20'(exp_err));
        do_cmd(BUSCMD_RESET, 20'h0);
        idle(1);
        check("rstcmd_err_clear", 20'(bus_error), 20'h0);

        // Reset mid-configuration overrides a coincident CONFIGURE.
        do_cmd(BUSCMD_CONFIGURE, 20'hFF000);
        idle(1);
        check("sized_state", 20'(dbg_state), 20'(SYSRAM_SIZED));
        check("sized_mask", dbg_mask, 20'hFF000);
        apply_reset(1'b1, BUSCMD_CONFIGURE, 20'h70000);
        check_reset_outputs("midcfg");

        // Configure: size then base; a third CONFIGURE is for the next chip.
        do_cmd(BUSCMD_CONFIGURE, 20'hFF000);
        do_cmd(BUSCMD_CONFIGURE, 20'h70000);
        idle(1);
        check("cfg_daisy_out", 20'(daisy_out), 20'h1);
        check("cfg_mask", dbg_mask, 20'hFF000);
        check("cfg_base", dbg_base, 20'h70000);
        do_cmd(BUSCMD_CONFIGURE, 20'h12345);
        idle(1);
        check("cfg3_base", dbg_base, 20'h70000);
        check("cfg3_state", 20'(dbg_state), 20'(SYSRAM_CONF));

        // Write A,B,C then read them back.
        do_cmd(BUSCMD_LOAD_DP, 20'h70010);
        do_cmd(BUSCMD_DP_WRITE, 20'h0, 4'hA);
        do_cmd(BUSCMD_DP_WRITE, 20'h0, 4'hB);
        do_cmd(BUSCMD_DP_WRITE, 20'h0, 4'hC);
        do_cmd(BUSCMD_LOAD_DP, 20'h70010);
        do_cmd(BUSCMD_DP_READ, 20'h0);
        do_cmd(BUSCMD_DP_READ, 20'h0);
        do_cmd(BUSCMD_DP_READ, 20'h0);
        idle(1);
        check("wr_rd_last_nib", 20'(nibble_out), 20'hC);
        check("wr_rd_dp_end", dbg_dp, 20'h70013);

        // Fetch across the top of the address space.
        do_cmd(BUSCMD_LOAD_PC, 20'hFFFFF);
        do_cmd(BUSCMD_PC_READ, 20'h0);
        idle(1);
        check("wrap_pc0", dbg_pc, 20'h00000);
        do_cmd(BUSCMD_PC_READ, 20'h0);
        idle(1);
        check("wrap_pc1", dbg_pc, 20'h00001);
        check("wrap_err", 20'(bus_error), 20'(exp_err));
        do_cmd(BUSCMD_LOAD_PC, 20'h70010);
        do_cmd(BUSCMD_PC_READ, 20'h0);
        idle(2);
        check("wrap_err_sticky", 20'(bus_error), 20'(exp_err));
        check("pc_hit_nib", 20'(nibble_out), 20'hA);

        // Back-to-back write then read of the same location.
        do_cmd(BUSCMD_LOAD_DP, 20'h70020);
        do_cmd(BUSCMD_DP_WRITE, 20'h0, 4'h5);
        do_cmd(BUSCMD_LOAD_DP, 20'h70020);
        do_cmd(BUSCMD_DP_READ, 20'h0);
        idle(1);
        check("b2b_nib", 20'(nibble_out), 20'h5);
        check("b2b_hit", 20'(hit), 20'h1);

        // Random traffic, mostly inside the window.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(9, 0))
                0:       cmd = BUSCMD_LOAD_PC;
                1:       cmd = BUSCMD_LOAD_DP;
                2, 3:    cmd = BUSCMD_PC_READ;
                4, 5:    cmd = BUSCMD_DP_READ;
                6, 7:    cmd = BUSCMD_DP_WRITE;
                8:       cmd = BUSCMD_CONFIGURE;
                default: cmd = ($urandom_range(1, 0) == 0) ? BUSCMD_NOP : BUSCMD_PC_WRITE;
            endcase
            a = ($urandom_range(4, 0) == 0) ? 20'($urandom) : (20'h70000 | 20'($urandom_range(4095, 0)));
            do_cmd(cmd, a, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
        end
        idle(1);
        check("rand_pc", dbg_pc, m_pc);
        check("rand_dp", dbg_dp, m_dp);

        // RESET command from the configured state.
        do_cmd(BUSCMD_RESET, 20'h0);
        idle(1);
        check("rstcmd_state", 20'(dbg_state), 20'(SYSRAM_UNCONF));
        check("rstcmd_daisy_out", 20'(daisy_out), 20'h0);
        check("rstcmd_mask", dbg_mask, 20'h0);
        check("rstcmd_base", dbg_base, 20'h0);

        idle(3);
        check("queue_drained", 20'(exp_q.size()), 20'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hp48_sysram_responder.md
# hp48_sysram_responder

Bus-side responder for the nibble-serial HP48 bus driven by the Saturn core. It decodes the `BUSCMD_*` stream and keeps its own PC and DP nibble pointers with post-increment. It implements the two-step HP48 size/base configuration handshake with a daisy chain, and serves a configurable nibble RAM window. It sits behind the bus controller as one memory chip on the daisy chain.

## Interface
- `DEPTH_LOG2`, default 12: RAM depth is 2^DEPTH_LOG2 nibbles (4096).
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `strobe`  in  1  one-cycle command-valid qualifier; `command`, `address` and `nibble_in` are sampled only when it is high.
- `command`  in  4  `BUSCMD_*` code from `bus_commands.v`.
- `address`  in  20  address for `LOAD_PC`, `LOAD_DP` and `CONFIGURE`.
- `nibble_in`  in  4  write data for `DP_WRITE`.
- `daisy_in`  in  1  high when this chip may accept `CONFIGURE`.
- `daisy_out`  out  1  high once this chip is fully configured.
- `nibble_out`  out  4  read data.
- `hit`  out  1  the last read or write access fell inside the window.
- `bus_error`  out  1  error flag (see Configuration).

## Operation
- **Configuration state machine:** UNCONF → SIZED → CONF.
  - UNCONF, strobe with `CONFIGURE` and `daisy_in`=1: `mask <= address`, go to SIZED.
  - SIZED, strobe with `CONFIGURE`: `base <= address & mask`, go to CONF.
  - `CONFIGURE` while in CONF, or while `daisy_in`=0: ignored (it belongs to the next chip on the chain).
  - `RESET` command: return to UNCONF; `mask` and `base` are cleared to 0.
- `daisy_out` = (state == CONF).
- **Pointer commands:**
  - `LOAD_PC`: `pc_ptr <= address`.
  - `LOAD_DP`: `dp_ptr <= address`.
  - Both pointers are 20 bits and wrap FFFFF→00000.
- **Window decode:** an access at address `a` is a hit when state == CONF and `(a & mask) == base`.
  - RAM index = `a[DEPTH_LOG2-1:0]`.
  - Window bits beyond the depth alias.
- **Data commands:**
  - `PC_READ`: read at `pc_ptr`, then `pc_ptr <= pc_ptr+1`.
  - `DP_READ`: read at `dp_ptr`, then `dp_ptr <= dp_ptr+1`.
  - `DP_WRITE`: write `nibble_in` at `dp_ptr` only on a hit, then `dp_ptr+1`.
  - Pointers increment whether or not the access hits.
  - A read miss sets `nibble_out` to 0 and `hit` to 0; the data-out lines are not driven by this chip.
- `NOP`, and any unlisted code, with strobe: no state change.
- **Reset values:**
  - Outputs: `nibble_out`=0, `hit`=0, `bus_error`=0, `daisy_out`=0.
  - Internal: `pc_ptr`=0, `dp_ptr`=0, `mask`=0, `base`=0, state UNCONF.
  - RAM contents are not reset.

## Timing
- Strobe at cycle N:
  - Read data on `nibble_out` and `hit` are registered and valid at N+1.
  - They hold until the next strobe that carries a data command.
- Pointer, state and RAM updates take effect at N+1. Back-to-back strobes at N and N+1 are legal and use the already-incremented pointer.
- Write at N followed by a read of the same address at N+1 returns the new data (the RAM is read-after-write coherent).
- `reset` high at any cycle overrides a coincident strobe, including mid-configuration: SIZED returns to UNCONF.
- `strobe` low: outputs hold and nothing changes.

## Configuration
- `SYSRAM_UNMAPPED_ERR_EN` defined:
  - Any `PC_READ`, `DP_READ` or `DP_WRITE` that misses, while at least one chip is configured (`daisy_out`=1 here, i.e. state == CONF), sets sticky `bus_error`.
  - A data command in UNCONF also sets it.
  - `bus_error` clears only on `reset` or the `RESET` command.
- Not defined: `bus_error` is tied 0 and misses are silent.

## Structure
- Shared package/include:
  - the `BUSCMD_*` codes (existing `bus_commands.v`);
  - the state encodings `SYSRAM_UNCONF`, `SYSRAM_SIZED`, `SYSRAM_CONF`;
  - the default `DEPTH_LOG2`.
- One sub-module, `sysram_nibble_mem`: single-port 2^DEPTH_LOG2×4 synchronous RAM with write-first behaviour.
- Decode, pointers and the state machine stay in the top module.

## Test plan
- **Configure:** `daisy_in`=1; `CONFIGURE` 0xFF000, then `CONFIGURE` 0x70000.
  - Expect `daisy_out`=1 after the second, `mask`=FF000, `base`=70000.
  - A third `CONFIGURE` with 0x12345 leaves `base` unchanged.
- **Write/read:** after configuration, `LOAD_DP` 0x70010; `DP_WRITE` A,B,C.
  - Then `LOAD_DP` 0x70010 and three `DP_READ`s.
  - Expect `nibble_out` A,B,C with `hit`=1; `dp_ptr` ends at 0x70013.
- **Fetch and wrap:** `LOAD_PC` 0xFFFFF, then two `PC_READ`s.
  - Expect both to miss (`hit`=0, `nibble_out`=0) and `pc_ptr` to wrap to 00000, then 00001.
  - With `SYSRAM_UNMAPPED_ERR_EN` defined, expect `bus_error`=1 and sticky.
- **Daisy chain gating:** `daisy_in`=0 with `CONFIGURE` 0xFF000.
  - Expect the state to stay UNCONF and a `DP_READ` at 0x70000 to miss.
- **Reset mid-configuration:** after the first `CONFIGURE` (state SIZED), assert `reset` together with a strobed `CONFIGURE`.
  - Expect UNCONF, `daisy_out`=0, all outputs 0.
  - A subsequent `RESET` command from CONF also gives UNCONF.
- **Back-to-back:** strobes at consecutive cycles: `DP_WRITE` 5 at 0x70020 then `DP_READ` after `LOAD_DP` 0x70020.
  - Expect 5 on `nibble_out` one cycle after the read strobe.
